// File: rtl/oldland_defines_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oldland_defines (package)
//  Description : Shared encodings for the oldland memory stage and its
//                byte-lane helper: access widths and stage state values.
//  Revision    : 1.0 - initial release
// ============================================================================
package oldland_defines;

    // Access width encodings as driven by the execute stage (2'b11 acts as word)
    localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

    // Memory stage state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/oldland_mem_lanes.sv
`default_nettype none
// ============================================================================
//  Module      : oldland_mem_lanes
//  Description : Purely combinational little-endian byte-lane logic:
//                byte enables, store data replication and load extraction
//                for byte, half and word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module oldland_mem_lanes
    import oldland_defines::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  bytesel,
    output logic [31:0] store_lanes,
    output logic [31:0] load_value
);

    logic [7:0]  w_load_byte;
    logic [15:0] w_load_half;

    // Halves ignore addr[0]; bytes use the full lane offset
    assign w_load_byte = load_data[{addr_lo, 3'b000} +: 8];
    assign w_load_half = load_data[{addr_lo[1], 4'b0000} +: 16];

    // Width-dependent lane selection; anything not byte/half behaves as word
    always_comb begin
        bytesel     = 4'b1111;
        store_lanes = store_data;
        load_value  = load_data;
        case (width)
            MEM_WIDTH_BYTE: begin
                bytesel     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_value  = {24'b0, w_load_byte};
            end
            MEM_WIDTH_HALF: begin
                bytesel     = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_value  = {16'b0, w_load_half};
            end
            MEM_WIDTH_WORD: begin
                bytesel     = 4'b1111;
                store_lanes = store_data;
                load_value  = load_data;
            end
            default: begin
                bytesel     = 4'b1111;
                store_lanes = store_data;
                load_value  = load_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/oldland_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : oldland_mem_stage
//  Description : Memory pipeline stage. Issues byte/half/word data-bus
//                accesses with an access/ack handshake, stalls upstream
//                while an access is outstanding, aborts on timeout and
//                hands load data or the ALU result to writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module oldland_mem_stage
    import oldland_defines::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mar,
    input  logic [31:0] mdr,
    input  logic [31:0] wr_val,
    input  logic        wr_result,
    input  logic [3:0]  rd_sel,
    output logic        stall,
    output logic [31:0] d_addr,
    output logic [31:0] d_data_out,
    output logic [3:0]  d_bytesel,
    output logic        d_wr_en,
    output logic        d_access,
    input  logic        d_ack,
    input  logic [31:0] d_data_in,
    output logic [31:0] wb_val,
    output logic        wb_en,
    output logic [3:0]  wb_rd_sel,
    output logic        data_abort
);

    localparam int                 c_cnt_w        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_cnt_w-1:0] r_count;
    logic [1:0]         r_width;
    logic [1:0]         r_addr_lo;
    logic [3:0]         r_rd_sel;
    logic               r_wr_result;

    logic               w_req;
    logic               w_timeout;
    logic [1:0]         w_lane_width;
    logic [1:0]         w_lane_addr;
    logic [3:0]         w_bytesel;
    logic [31:0]        w_store_lanes;
    logic [31:0]        w_load_value;

    assign w_req     = mem_load | mem_store;
    // Last BUSY cycle before the counter would reach TIMEOUT_CYCLES
    assign w_timeout = (r_count == c_timeout_last);

    // One lane unit: IDLE needs request-side lanes, BUSY needs latched ones
    assign w_lane_width = (r_state == ST_IDLE) ? mem_width : r_width;
    assign w_lane_addr  = (r_state == ST_IDLE) ? mar[1:0]  : r_addr_lo;

    oldland_mem_lanes u_lanes (
        .width       (w_lane_width),
        .addr_lo     (w_lane_addr),
        .store_data  (mdr),
        .load_data   (d_data_in),
        .bytesel     (w_bytesel),
        .store_lanes (w_store_lanes),
        .load_value  (w_load_value)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, stall and abort; stall is gated by reset so a held
    // request cannot assert it while the stage is in reset
    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        data_abort   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall = w_req & rst_n;
                if (w_req) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (d_ack) begin
                    w_state_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                    data_abort   = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus request, latched access fields, timeout counter and writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_addr      <= 32'b0;
            d_data_out  <= 32'b0;
            d_bytesel   <= 4'b0;
            d_wr_en     <= 1'b0;
            d_access    <= 1'b0;
            wb_val      <= 32'b0;
            wb_en       <= 1'b0;
            wb_rd_sel   <= 4'b0;
            r_count     <= '0;
            r_width     <= 2'b0;
            r_addr_lo   <= 2'b0;
            r_rd_sel    <= 4'b0;
            r_wr_result <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        d_access    <= 1'b1;
                        d_addr      <= {mar[31:2], 2'b00};
                        d_bytesel   <= w_bytesel;
                        d_data_out  <= w_store_lanes;
                        d_wr_en     <= mem_store;
                        r_width     <= mem_width;
                        r_addr_lo   <= mar[1:0];
                        r_rd_sel    <= rd_sel;
                        r_wr_result <= wr_result;
                        r_count     <= '0;
                        wb_en       <= 1'b0;
                    end else begin
                        wb_val      <= wr_val;
                        wb_en       <= wr_result;
                        wb_rd_sel   <= rd_sel;
                    end
                end
                ST_BUSY: begin
                    if (d_ack || w_timeout) begin
                        d_access <= 1'b0;
                        r_count  <= '0;
                        if (d_wr_en) begin
                            wb_en     <= 1'b0;
                        end else begin
                            // An ack in the timeout cycle still delivers data
                            wb_val    <= d_ack ? w_load_value : 32'b0;
                            wb_en     <= r_wr_result;
                            wb_rd_sel <= r_rd_sel;
                        end
                    end else begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                default: begin
                    d_access <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oldland_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_oldland_mem_stage
//  Description : Self-checking bench for oldland_mem_stage with directed
//                scenarios and randomized transactions against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_oldland_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_load, mem_store;
    logic [1:0]  mem_width;
    logic [31:0] mar, mdr, wr_val;
    logic        wr_result;
    logic [3:0]  rd_sel;
    logic        stall;
    logic [31:0] d_addr, d_data_out;
    logic [3:0]  d_bytesel;
    logic        d_wr_en, d_access, d_ack;
    logic [31:0] d_data_in;
    logic [31:0] wb_val;
    logic        wb_en;
    logic [3:0]  wb_rd_sel;
    logic        data_abort;

    int n_checks = 0;
    int n_errors = 0;

    oldland_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_width  (mem_width),
        .mar        (mar),
        .mdr        (mdr),
        .wr_val     (wr_val),
        .wr_result  (wr_result),
        .rd_sel     (rd_sel),
        .stall      (stall),
        .d_addr     (d_addr),
        .d_data_out (d_data_out),
        .d_bytesel  (d_bytesel),
        .d_wr_en    (d_wr_en),
        .d_access   (d_access),
        .d_ack      (d_ack),
        .d_data_in  (d_data_in),
        .wb_val     (wb_val),
        .wb_en      (wb_en),
        .wb_rd_sel  (wb_rd_sel),
        .data_abort (data_abort)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    function automatic int m_nbytes(input logic [1:0] w);
        if (w == 2'd0) return 1;
        if (w == 2'd1) return 2;
        return 4;
    endfunction

    // Byte offset of the access: address rounded down to the access size
    function automatic int m_offset(input logic [1:0] w, input logic [1:0] a);
        int n;
        n = m_nbytes(w);
        return int'(a) - (int'(a) % n);
    endfunction

    function automatic logic [3:0] m_bytesel(input logic [1:0] w, input logic [1:0] a);
        int n;
        n = m_nbytes(w);
        return 4'(((1 << n) - 1) << m_offset(w, a));
    endfunction

    function automatic logic [31:0] m_store(input logic [1:0] w, input logic [31:0] md);
        logic [31:0] r;
        int n;
        n = m_nbytes(w);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = md[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = m_nbytes(w);
        r = d >> (8 * m_offset(w, a));
        if (n < 4) r = r & ((32'd1 << (8 * n)) - 32'd1);
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_load  = 1'b0;
        mem_store = 1'b0;
        wr_result = 1'b0;
        d_ack     = 1'b0;
    endtask

    // One memory instruction from request to exit. ack_dly is the BUSY
    // cycle index (0-based) carrying d_ack; ack_dly >= TO means no ack.
    task automatic mem_op(input logic st, input logic ld, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] md,
                          input logic wres, input logic [3:0] rd,
                          input int ack_dly, input logic [31:0] rdata,
                          input string nm);
        logic [31:0] exp_addr, exp_data, exp_val;
        logic [3:0]  exp_sel;
        bit          done, acked;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_sel  = m_bytesel(w, a[1:0]);
        exp_data = m_store(w, md);
        acked    = 1'b0;
        mem_load = ld; mem_store = st; mem_width = w; mar = a; mdr = md;
        wr_result = wres; rd_sel = rd; wr_val = $urandom; d_ack = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++; $display("FAIL %s req_stall: stall=%0b expected 1", nm, stall);
        end
        next_cycle();
        n_checks++;
        if (d_access !== 1'b1 || d_wr_en !== st || d_addr !== exp_addr || wb_en !== 1'b0) begin
            n_errors++;
            $display("FAIL %s bus_req: access=%0b wr_en=%0b addr=%h wb_en=%0b expected 1 %0b %h 0",
                     nm, d_access, d_wr_en, d_addr, wb_en, st, exp_addr);
        end
        n_checks++;
        if (d_bytesel !== exp_sel || (st && d_data_out !== exp_data)) begin
            n_errors++;
            $display("FAIL %s lanes: bytesel=%b data_out=%h expected %b %h",
                     nm, d_bytesel, d_data_out, exp_sel, exp_data);
        end
        done = 1'b0;
        for (int k = 0; !done; k++) begin
            if (k == ack_dly) begin
                d_ack = 1'b1; d_data_in = rdata; #1;
                n_checks++;
                if (stall !== 1'b0 || data_abort !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s ack_cycle: stall=%0b abort=%0b expected 0 0", nm, stall, data_abort);
                end
                acked = 1'b1; done = 1'b1;
            end else if (k == TO - 1) begin
                d_data_in = $urandom; #1;
                n_checks++;
                if (data_abort !== 1'b1 || stall !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s timeout_cycle: abort=%0b stall=%0b expected 1 0", nm, data_abort, stall);
                end
                done = 1'b1;
            end else begin
                d_data_in = $urandom; #1;
                n_checks++;
                if (stall !== 1'b1 || data_abort !== 1'b0 || d_access !== 1'b1 || wb_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s busy_cycle%0d: stall=%0b abort=%0b access=%0b wb_en=%0b expected 1 0 1 0",
                             nm, k, stall, data_abort, d_access, wb_en);
                end
            end
            next_cycle();
        end
        idle_inputs();
        n_checks++;
        if (d_access !== 1'b0 || data_abort !== 1'b0) begin
            n_errors++;
            $display("FAIL %s exit: access=%0b abort=%0b expected 0 0", nm, d_access, data_abort);
        end
        n_checks++;
        if (st) begin
            if (wb_en !== 1'b0) begin
                n_errors++; $display("FAIL %s store_wb: wb_en=%0b expected 0", nm, wb_en);
            end
        end else begin
            exp_val = acked ? m_load(w, a[1:0], rdata) : 32'd0;
            if (wb_en !== wres || wb_val !== exp_val || (acked && wb_rd_sel !== rd)) begin
                n_errors++;
                $display("FAIL %s load_wb: en=%0b val=%h rd=%0d expected %0b %h %0d",
                         nm, wb_en, wb_val, wb_rd_sel, wres, exp_val, rd);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        mem_width = 2'b0; mar = '0; mdr = '0; wr_val = '0; rd_sel = '0; d_data_in = '0;
        next_cycle();
        next_cycle();
        n_checks++;
        if ({stall, d_access, d_wr_en, data_abort, wb_en} !== 5'b0 || d_addr !== 32'd0 ||
            d_data_out !== 32'd0 || d_bytesel !== 4'd0 || wb_val !== 32'd0 || wb_rd_sel !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_state: stall=%0b access=%0b wr_en=%0b abort=%0b wb_en=%0b addr=%h dout=%h sel=%b wbv=%h rd=%0d expected all 0",
                     stall, d_access, d_wr_en, data_abort, wb_en, d_addr, d_data_out, d_bytesel, wb_val, wb_rd_sel);
        end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic passthrough(input logic [31:0] v, input logic r, input logic [3:0] rd, input string nm);
        mem_load = 1'b0; mem_store = 1'b0; wr_val = v; wr_result = r; rd_sel = rd;
        mar = $urandom; mem_width = 2'($urandom);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++; $display("FAIL %s stall: stall=%0b expected 0", nm, stall);
        end
        next_cycle();
        n_checks++;
        if (wb_val !== v || wb_en !== r || wb_rd_sel !== rd) begin
            n_errors++;
            $display("FAIL %s wb: val=%h en=%0b rd=%0d expected %h %0b %0d", nm, wb_val, wb_en, wb_rd_sel, v, r, rd);
        end
    endtask

    task automatic test_passthrough();
        passthrough(32'h55, 1'b1, 4'd7, "pass_fixed");
        for (int i = 0; i < 6; i++)
            passthrough($urandom, 1'($urandom), 4'($urandom), "pass_rand");
    endtask

    task automatic test_word_load();
        mem_op(1'b0, 1'b1, 2'b10, 32'h100, 32'h0, 1'b1, 4'd3, 2, 32'hDEADBEEF, "word_load");
    endtask

    task automatic test_byte_store();
        mem_op(1'b1, 1'b0, 2'b00, 32'h203, 32'h000000A5, 1'b1, 4'd2, 1, 32'h0, "byte_store");
    endtask

    task automatic test_half_load();
        mem_op(1'b0, 1'b1, 2'b01, 32'h42, 32'h0, 1'b1, 4'd9, 0, 32'h1234ABCD, "half_load");
    endtask

    task automatic test_timeout();
        mem_op(1'b0, 1'b1, 2'b10, 32'h400, 32'h0, 1'b1, 4'd4, TO, 32'h0, "timeout_load");
        mem_op(1'b1, 1'b0, 2'b01, 32'h402, 32'hBEEF, 1'b0, 4'd4, TO, 32'h0, "timeout_store");
        mem_op(1'b0, 1'b1, 2'b00, 32'h411, 32'h0, 1'b1, 4'd6, TO - 1, 32'h00C30000, "ack_at_timeout");
    endtask

    task automatic test_back_to_back();
        mem_op(1'b1, 1'b1, 2'b11, 32'h500, 32'hCAFEF00D, 1'b1, 4'd1, 0, 32'h0, "b2b_both");
        mem_op(1'b0, 1'b1, 2'b00, 32'h501, 32'h0, 1'b1, 4'd8, 0, 32'h00007700, "b2b_byte");
        mem_op(1'b0, 1'b1, 2'b11, 32'h507, 32'h0, 1'b1, 4'd10, 1, 32'h89ABCDEF, "b2b_w11");
    endtask

    task automatic test_reset_mid_busy();
        mem_load = 1'b1; mem_store = 1'b0; mem_width = 2'b10; mar = 32'h300;
        wr_result = 1'b1; rd_sel = 4'd5; d_ack = 1'b0;
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (d_access !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_busy: access=%0b stall=%0b wb_en=%0b expected 0 0 0", d_access, stall, wb_en);
        end
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        wr_val = 32'h1111_2222; rd_sel = 4'd12;
        d_ack = 1'b1; d_data_in = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (stall !== 1'b0 || data_abort !== 1'b0) begin
            n_errors++;
            $display("FAIL late_ack_comb: stall=%0b abort=%0b expected 0 0", stall, data_abort);
        end
        next_cycle();
        d_ack = 1'b0;
        n_checks++;
        if (d_access !== 1'b0 || wb_en !== 1'b0 || wb_val !== 32'h1111_2222) begin
            n_errors++;
            $display("FAIL late_ack_ignored: access=%0b wb_en=%0b wb_val=%h expected 0 0 11112222",
                     d_access, wb_en, wb_val);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                passthrough($urandom, 1'($urandom), 4'($urandom), "rand_pass");
            end else begin
                kind = $urandom_range(0, 2);
                mem_op(kind != 0, kind != 1, 2'($urandom), $urandom, $urandom,
                       1'($urandom), 4'($urandom), $urandom_range(0, TO), $urandom, "rand_mem");
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_word_load();
        test_byte_store();
        test_half_load();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
